// File: rtl/apb_timer_pkg.sv
// Shared register offsets, CTRL bit positions and bus-phase encoding for apb_timer_regs.
package apb_timer_pkg;

   localparam logic [31:0] CTRL_OFS  = 32'h0000_0000;
   localparam logic [31:0] LOAD_OFS  = 32'h0000_0004;
   localparam logic [31:0] COUNT_OFS = 32'h0000_0008;
   localparam logic [31:0] STAT_OFS  = 32'h0000_000C;
   localparam logic [31:0] SCR_OFS   = 32'h0000_0010;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_AR_BIT  = 1;
   localparam int unsigned CTRL_IRQ_BIT = 2;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

endpackage

// File: rtl/apb_timer_core.sv
// Down-counter with optional auto-reload and a sticky EXPIRED flag (write-1-to-clear).
module apb_timer_core
   import apb_timer_pkg::*;
#(
   parameter logic [31:0] LOAD_RST = 32'h0000_0000
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        en,
   input  logic        auto_reload,
   input  logic        load_wr,
   input  logic [31:0] load_val,
   input  logic [31:0] reload_val,
   input  logic        stat_w1c,
   output logic [31:0] count,
   output logic        expired
);

   logic [31:0] count_q, count_d;
   logic        expired_q, expired_d;

   always_comb begin
      count_d   = count_q;
      expired_d = expired_q;
      if (stat_w1c) begin
         expired_d = 1'b0;
      end
      // A decrement to zero outranks a same-cycle clear; a LOAD write outranks everything.
      if (en) begin
         if (count_q != '0) begin
            count_d = count_q - 32'd1;
            if (count_q == 32'd1) begin
               expired_d = 1'b1;
            end
         end else if (auto_reload) begin
            count_d = reload_val;
         end
      end
      if (load_wr) begin
         count_d = load_val;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         count_q   <= LOAD_RST;
         expired_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         expired_q <= expired_d;
      end
   end

   assign count   = count_q;
   assign expired = expired_q;

endmodule

// File: rtl/apb_timer_regs.sv
// APB register bank for the down-counter timer: CTRL, LOAD, COUNT, STATUS, SCRATCH.
// Define APB_TIMER_SLVERR_EN to add the pslverr output.
module apb_timer_regs
   import apb_timer_pkg::*;
#(
   parameter int unsigned DEC_W       = 8,
   parameter logic [31:0] SCRATCH_RST = 32'h0000_0000,
   parameter logic [31:0] LOAD_RST    = 32'h0000_0000
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        irq
`ifdef APB_TIMER_SLVERR_EN
   ,
   output logic        pslverr
`endif
);

   apb_state_e  state_q, state_d;
   logic [31:0] ofs;
   logic        hit_ctrl, hit_load, hit_count, hit_stat, hit_scr, unmapped;
   logic        wr_en, rd_en, load_wr, stat_w1c;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] load_q, load_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] prdata_q, prdata_d;
   logic [31:0] rdata;
   logic [31:0] count;
   logic        expired;
   logic        unused_paddr_hi;

   assign unused_paddr_hi = ^paddr[31:DEC_W];

   // state_d is the phase of the current bus cycle; state_q remembers the previous one.
   always_comb begin
      state_d = IDLE;
      unique case (state_q)
         IDLE: begin
            if (psel && !penable) state_d = SETUP;
         end
         SETUP: begin
            if (psel && penable)       state_d = ACCESS;
            else if (psel && !penable) state_d = SETUP;
         end
         ACCESS: begin
            if (psel && !penable) state_d = SETUP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ofs             = '0;
      ofs[DEC_W-1:0]  = paddr[DEC_W-1:0];
   end

   assign hit_ctrl  = (ofs == CTRL_OFS);
   assign hit_load  = (ofs == LOAD_OFS);
   assign hit_count = (ofs == COUNT_OFS);
   assign hit_stat  = (ofs == STAT_OFS);
   assign hit_scr   = (ofs == SCR_OFS);
   assign unmapped  = !(hit_ctrl || hit_load || hit_count || hit_stat || hit_scr);

   assign wr_en    = (state_d == ACCESS) && pwrite;
   assign rd_en    = (state_d == SETUP) && !pwrite;
   assign load_wr  = wr_en && hit_load;
   assign stat_w1c = wr_en && hit_stat && pwdata[0];

   always_comb begin
      ctrl_d    = ctrl_q;
      load_d    = load_q;
      scratch_d = scratch_q;
      if (wr_en) begin
         if (hit_ctrl) ctrl_d    = pwdata[2:0];
         if (hit_load) load_d    = pwdata;
         if (hit_scr)  scratch_d = pwdata;
      end
   end

   always_comb begin
      rdata = '0;
      if (hit_ctrl)  rdata = {29'd0, ctrl_q};
      if (hit_load)  rdata = load_q;
      if (hit_count) rdata = count;
      if (hit_stat)  rdata = {31'd0, expired};
      if (hit_scr)   rdata = scratch_q;
   end

   always_comb begin
      prdata_d = prdata_q;
      if (rd_en) prdata_d = rdata;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= IDLE;
         ctrl_q    <= '0;
         load_q    <= LOAD_RST;
         scratch_q <= SCRATCH_RST;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         scratch_q <= scratch_d;
         prdata_q  <= prdata_d;
      end
   end

   apb_timer_core #(
      .LOAD_RST (LOAD_RST)
   ) u_core (
      .pclk        (pclk),
      .presetn     (presetn),
      .en          (ctrl_q[CTRL_EN_BIT]),
      .auto_reload (ctrl_q[CTRL_AR_BIT]),
      .load_wr     (load_wr),
      .load_val    (pwdata),
      .reload_val  (load_q),
      .stat_w1c    (stat_w1c),
      .count       (count),
      .expired     (expired)
   );

   assign prdata = prdata_q;
   assign irq    = expired & ctrl_q[CTRL_IRQ_BIT];

`ifdef APB_TIMER_SLVERR_EN
   logic pslverr_q, pslverr_d;

   always_comb begin
      pslverr_d = 1'b0;
      if (state_d == SETUP) pslverr_d = unmapped || (pwrite && hit_count);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) pslverr_q <= 1'b0;
      else          pslverr_q <= pslverr_d;
   end

   assign pslverr = pslverr_q;
`endif

endmodule

// File: tb/tb_apb_timer_regs.sv
// Directed self-checking bench for apb_timer_regs; expected values are hand-derived cycle by cycle.
module tb_apb_timer_regs;
   import apb_timer_pkg::*;

   logic        pclk;
   logic        presetn;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        irq;
`ifdef APB_TIMER_SLVERR_EN
   logic        pslverr;
`endif
   logic        last_err;

   int unsigned vec_cnt;
   int unsigned err_cnt;

   apb_timer_regs #(
      .DEC_W       (8),
      .SCRATCH_RST (32'h0000_0000),
      .LOAD_RST    (32'h0000_0000)
   ) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .irq     (irq)
`ifdef APB_TIMER_SLVERR_EN
      ,
      .pslverr (pslverr)
`endif
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Tasks start and end 1 time unit after a rising edge.
   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(posedge pclk); #1;
      penable = 1'b1;
      d = prdata;
`ifdef APB_TIMER_SLVERR_EN
      last_err = pslverr;
`else
      last_err = 1'b0;
`endif
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;
      #1;
      vec_cnt++;
      if (prdata !== 32'h0 || irq !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_out: prdata=%h irq=%b want 00000000/0", prdata, irq);
      end
      repeat (2) @(posedge pclk);
      #1 presetn = 1'b1;
      apb_write(SCR_OFS, 32'h1111_1111);
      apb_read(SCR_OFS, d);
      vec_cnt++;
      if (d !== 32'h1111_1111) begin
         err_cnt++;
         $display("FAIL reset_pre_scr: got %h want 11111111", d);
      end
      // Start a SCRATCH write and pull reset during its access phase.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = SCR_OFS; pwdata = 32'hDEAD_BEEF;
      @(posedge pclk); #1;
      penable = 1'b1;
      #2 presetn = 1'b0;
      #1;
      vec_cnt++;
      if (prdata !== 32'h0 || irq !== 1'b0 || dut.state_q !== IDLE) begin
         err_cnt++;
         $display("FAIL reset_mid: prdata=%h irq=%b state=%0d want 0/0/IDLE",
                  prdata, irq, dut.state_q);
      end
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1 presetn = 1'b1;
      apb_read(SCR_OFS, d);
      vec_cnt++;
      if (d !== 32'h0) begin
         err_cnt++;
         $display("FAIL reset_scr: got %h want 00000000", d);
      end
   endtask

   task automatic test_rw();
      logic [31:0] d;
      apb_write(SCR_OFS, 32'hA5A5_5A5A);
      apb_read(SCR_OFS, d);
      vec_cnt++;
      if (d !== 32'hA5A5_5A5A) begin
         err_cnt++;
         $display("FAIL scratch_rw: got %h want a5a55a5a", d);
      end
      apb_write(CTRL_OFS, 32'hFFFF_FFFF);
      apb_read(CTRL_OFS, d);
      vec_cnt++;
      if (d !== 32'h0000_0007) begin
         err_cnt++;
         $display("FAIL ctrl_mask: got %h want 00000007", d);
      end
      apb_write(CTRL_OFS, 32'h0);
      apb_read(STAT_OFS, d);
      vec_cnt++;
      if (d !== 32'h0) begin
         err_cnt++;
         $display("FAIL reload_zero_no_expire: got %h want 00000000", d);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      logic [31:0] exp_a [5];
      logic [31:0] exp_b [3];
      exp_a = '{32'd5, 32'd3, 32'd1, 32'd0, 32'd0};
      exp_b = '{32'd4, 32'd2, 32'd0};
      apb_write(LOAD_OFS, 32'd5);
      apb_write(CTRL_OFS, 32'h1);
      for (int i = 0; i < 5; i++) begin
         apb_read(COUNT_OFS, d);
         vec_cnt++;
         if (d !== exp_a[i]) begin
            err_cnt++;
            $display("FAIL oneshot_even[%0d]: got %0d want %0d", i, d, exp_a[i]);
         end
      end
      // Reload and skip a cycle to observe the odd counts.
      apb_write(LOAD_OFS, 32'd5);
      @(posedge pclk); #1;
      for (int i = 0; i < 3; i++) begin
         apb_read(COUNT_OFS, d);
         vec_cnt++;
         if (d !== exp_b[i]) begin
            err_cnt++;
            $display("FAIL oneshot_odd[%0d]: got %0d want %0d", i, d, exp_b[i]);
         end
      end
      apb_read(STAT_OFS, d);
      vec_cnt++;
      if (d !== 32'h1 || irq !== 1'b0) begin
         err_cnt++;
         $display("FAIL oneshot_status: status=%h irq=%b want 00000001/0", d, irq);
      end
      apb_write(CTRL_OFS, 32'h0);
      apb_write(STAT_OFS, 32'h1);
      apb_read(STAT_OFS, d);
      vec_cnt++;
      if (d !== 32'h0) begin
         err_cnt++;
         $display("FAIL w1c: got %h want 00000000", d);
      end
   endtask

   task automatic test_autoreload();
      logic [31:0] d;
      logic        exp_irq [4];
      exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1};
      apb_write(LOAD_OFS, 32'd3);
      apb_write(CTRL_OFS, 32'h7);
      apb_read(COUNT_OFS, d);
      vec_cnt++;
      if (d !== 32'd3 || irq !== 1'b0) begin
         err_cnt++;
         $display("FAIL ar_r1: count=%0d irq=%b want 3/0", d, irq);
      end
      apb_read(COUNT_OFS, d);
      vec_cnt++;
      if (d !== 32'd1 || irq !== 1'b1) begin
         err_cnt++;
         $display("FAIL ar_r2: count=%0d irq=%b want 1/1", d, irq);
      end
      apb_read(COUNT_OFS, d);
      vec_cnt++;
      if (d !== 32'd3) begin
         err_cnt++;
         $display("FAIL ar_reload: count=%0d want 3", d);
      end
      apb_write(STAT_OFS, 32'h1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(posedge pclk); #1;
         end
         vec_cnt++;
         if (irq !== exp_irq[i]) begin
            err_cnt++;
            $display("FAIL ar_irq[%0d]: got %b want %b", i, irq, exp_irq[i]);
         end
      end
      apb_write(CTRL_OFS, 32'h0);
      apb_write(STAT_OFS, 32'h1);
   endtask

   task automatic test_set_wins();
      logic [31:0] d;
      apb_write(LOAD_OFS, 32'd3);
      apb_read(STAT_OFS, d);
      vec_cnt++;
      if (d !== 32'h0) begin
         err_cnt++;
         $display("FAIL setwins_pre: got %h want 00000000", d);
      end
      apb_write(CTRL_OFS, 32'h1);
      @(posedge pclk); #1;
      apb_write(STAT_OFS, 32'h1);
      apb_read(STAT_OFS, d);
      vec_cnt++;
      if (d !== 32'h1 || irq !== 1'b0) begin
         err_cnt++;
         $display("FAIL setwins: status=%h irq=%b want 00000001/0", d, irq);
      end
      apb_read(COUNT_OFS, d);
      vec_cnt++;
      if (d !== 32'd0) begin
         err_cnt++;
         $display("FAIL setwins_count: got %0d want 0", d);
      end
      apb_write(CTRL_OFS, 32'h0);
      apb_write(STAT_OFS, 32'h1);
   endtask

   task automatic test_reload_load();
      logic [31:0] d;
      apb_write(LOAD_OFS, 32'd2);
      apb_write(CTRL_OFS, 32'h3);
      @(posedge pclk); #1;
      apb_write(LOAD_OFS, 32'h10);
      apb_read(COUNT_OFS, d);
      vec_cnt++;
      if (d !== 32'h10) begin
         err_cnt++;
         $display("FAIL reload_edge_load: got %h want 00000010", d);
      end
      apb_read(STAT_OFS, d);
      vec_cnt++;
      if (d !== 32'h1) begin
         err_cnt++;
         $display("FAIL reload_edge_status: got %h want 00000001", d);
      end
      apb_write(CTRL_OFS, 32'h0);
      apb_write(STAT_OFS, 32'h1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      apb_write(LOAD_OFS, 32'hCAFE_F00D);
      apb_read(LOAD_OFS, d);
      vec_cnt++;
      if (d !== 32'hCAFE_F00D) begin
         err_cnt++;
         $display("FAIL b2b_load: got %h want cafef00d", d);
      end
      apb_write(COUNT_OFS, 32'h0000_0055);
      apb_read(COUNT_OFS, d);
      vec_cnt++;
      if (d !== 32'hCAFE_F00D) begin
         err_cnt++;
         $display("FAIL count_ro: got %h want cafef00d", d);
      end
      apb_read(32'h0000_0040, d);
      vec_cnt++;
      if (d !== 32'h0) begin
         err_cnt++;
         $display("FAIL unmapped_rd: got %h want 00000000", d);
      end
`ifdef APB_TIMER_SLVERR_EN
      vec_cnt++;
      if (last_err !== 1'b1) begin
         err_cnt++;
         $display("FAIL slverr_unmapped: got %b want 1", last_err);
      end
      apb_read(SCR_OFS, d);
      vec_cnt++;
      if (last_err !== 1'b0) begin
         err_cnt++;
         $display("FAIL slverr_mapped: got %b want 0", last_err);
      end
`endif
      apb_read(32'h0000_0110, d);
      vec_cnt++;
      if (d !== 32'hA5A5_5A5A) begin
         err_cnt++;
         $display("FAIL upper_addr_ignored: got %h want a5a55a5a", d);
      end
      apb_read(32'h0000_0002, d);
      vec_cnt++;
      if (d !== 32'h0) begin
         err_cnt++;
         $display("FAIL unaligned_rd: got %h want 00000000", d);
      end
   endtask

   task automatic test_protocol_error();
      logic [31:0] d;
      apb_read(SCR_OFS, d);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = SCR_OFS; pwdata = 32'h0BAD_0BAD;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      apb_read(SCR_OFS, d);
      vec_cnt++;
      if (d !== 32'hA5A5_5A5A) begin
         err_cnt++;
         $display("FAIL proto_no_write: got %h want a5a55a5a", d);
      end
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = CTRL_OFS;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      vec_cnt++;
      if (prdata !== 32'hA5A5_5A5A) begin
         err_cnt++;
         $display("FAIL proto_no_read: got %h want a5a55a5a", prdata);
      end
   endtask

   initial begin
      vec_cnt  = 0;
      err_cnt  = 0;
      last_err = 1'b0;
      test_reset();
      test_rw();
      test_oneshot();
      test_autoreload();
      test_set_wins();
      test_reload_load();
      test_back_to_back();
      test_protocol_error();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
